// File: rtl/wb_exc_stage_if.sv
// Pipeline-side signal bundle of the write-back/exception stage.
//   master : upstream (memory stage) drives the instruction handshake and
//            observes everything the stage produces.
//   slave  : the write-back stage itself.
// Signals:
//   ws_allowin        stage can accept a new instruction
//   ms_to_ws_valid    upstream instruction valid
//   ms_to_ws_bus      packed instruction from the memory stage (123 bits)
//   ws_to_rf_bus      {rf_we[4], rf_waddr[5], rf_wdata[32]}
//   stall_ws_bus      {valid & |we, we & {4{valid}}, dest}
//   forward_ws_bus    {ws_valid, rf_wdata}
//   ws_flush          pipeline flush request this cycle
//   ws_flush_pc       fetch redirect target, valid with ws_flush
//   debug_wb_*        retire trace
interface wb_exc_stage_if;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [122:0] ms_to_ws_bus;
  logic [40:0]  ws_to_rf_bus;
  logic [9:0]   stall_ws_bus;
  logic [32:0]  forward_ws_bus;
  logic         ws_flush;
  logic [31:0]  ws_flush_pc;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  modport master (
    input  ws_allowin,
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    input  ws_to_rf_bus,
    input  stall_ws_bus,
    input  forward_ws_bus,
    input  ws_flush,
    input  ws_flush_pc,
    input  debug_wb_pc,
    input  debug_wb_rf_wen,
    input  debug_wb_rf_wnum,
    input  debug_wb_rf_wdata
  );

  modport slave (
    output ws_allowin,
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    output ws_to_rf_bus,
    output stall_ws_bus,
    output forward_ws_bus,
    output ws_flush,
    output ws_flush_pc,
    output debug_wb_pc,
    output debug_wb_rf_wen,
    output debug_wb_rf_wnum,
    output debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_exc_stage.sv
// Write-back stage with integrated CP0 and precise exception/interrupt entry.
// Holds one instruction from the memory stage, writes the register file,
// services mfc0/mtc0, takes exceptions and interrupts (flushing to EXC_ENTRY)
// and executes eret (flushing to EPC). Contains the Count/Compare timer.
// Ports:
//   clk     sole clock, all state updates on the rising edge
//   reset   synchronous, active-high
//   hw_int  level-sensitive hardware interrupt lines
//   pipe    pipeline bundle (slave side), see wb_exc_stage_if
module wb_exc_stage #(
  parameter int unsigned NUM_HW_INT = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] EXC_ENTRY  = 32'hBFC0_0380
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_HW_INT-1:0] hw_int,
  wb_exc_stage_if.slave         pipe
);

  localparam int unsigned     DivW    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(COUNT_DIV - 1);

  localparam logic [7:0] AddrBadVAddr = 8'h40;
  localparam logic [7:0] AddrCount    = 8'h48;
  localparam logic [7:0] AddrCompare  = 8'h58;
  localparam logic [7:0] AddrStatus   = 8'h60;
  localparam logic [7:0] AddrCause    = 8'h68;
  localparam logic [7:0] AddrEpc      = 8'h70;

  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;

  // Pipeline register
  logic         ws_valid_q, ws_valid_d;
  logic [122:0] ws_bus_q, ws_bus_d;
  logic         ws_ready_go;
  logic         ws_allowin;

  // Instruction fields held in the stage
  logic [31:0] ws_bad_vaddr;
  logic [4:0]  ws_ex_code;
  logic        ws_has_exc;
  logic        ws_is_slot;
  logic        ws_eret;
  logic        ws_cp0_wen;
  logic        ws_res_from_cp0;
  logic [7:0]  ws_cp0_addr;
  logic [3:0]  ws_gr_we;
  logic [4:0]  ws_dest;
  logic [31:0] ws_result;
  logic [31:0] ws_pc;

  // CP0 state
  logic [7:0]      status_im_q, status_im_d;
  logic            status_exl_q, status_exl_d;
  logic            status_ie_q, status_ie_d;
  logic            cause_bd_q, cause_bd_d;
  logic            cause_ti_q, cause_ti_d;
  logic [5:0]      cause_ip_hw_q, cause_ip_hw_d;  // Cause.IP[7:2]
  logic [1:0]      cause_ip_sw_q, cause_ip_sw_d;  // Cause.IP[1:0]
  logic [4:0]      cause_exc_q, cause_exc_d;
  logic [31:0]     epc_q, epc_d;
  logic [31:0]     badvaddr_q, badvaddr_d;
  logic [31:0]     count_q, count_d;
  logic [31:0]     compare_q, compare_d;
  logic [DivW-1:0] div_q, div_d;

  // Control
  logic [5:0]  hw_ext;
  logic [7:0]  cause_ip;
  logic        int_req;
  logic        take_int;
  logic        take_exc;
  logic [4:0]  exc_code;
  logic        eret_go;
  logic        cp0_we;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;
  logic [31:0] cp0_rdata;
  logic [3:0]  rf_we;
  logic [31:0] rf_wdata;
  logic        flush;
  logic [31:0] flush_pc;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = !ws_valid_q | ws_ready_go;

  assign ws_bad_vaddr    = ws_bus_q[122:91];
  assign ws_ex_code      = ws_bus_q[90:86];
  assign ws_has_exc      = ws_bus_q[85];
  assign ws_is_slot      = ws_bus_q[84];
  assign ws_eret         = ws_bus_q[83];
  assign ws_cp0_wen      = ws_bus_q[82];
  assign ws_res_from_cp0 = ws_bus_q[81];
  assign ws_cp0_addr     = ws_bus_q[80:73];
  assign ws_gr_we        = ws_bus_q[72:69];
  assign ws_dest         = ws_bus_q[68:64];
  assign ws_result       = ws_bus_q[63:32];
  assign ws_pc           = ws_bus_q[31:0];

  // Zero-extend the interrupt lines to the six IP slots
  always_comb begin
    hw_ext                 = '0;
    hw_ext[NUM_HW_INT-1:0] = hw_int;
  end

  assign cause_ip = {cause_ip_hw_q, cause_ip_sw_q};
  assign int_req  = status_ie_q & !status_exl_q & (|(cause_ip & status_im_q));
  assign take_int = ws_valid_q & int_req;
  assign take_exc = ws_valid_q & (take_int | ws_has_exc);
  // An interrupt outranks any exception the instruction itself raised
  assign exc_code = take_int ? 5'd0 : ws_ex_code;
  assign eret_go  = ws_valid_q & ws_eret & !take_exc;
  assign cp0_we   = ws_valid_q & ws_cp0_wen & !take_exc;

  // Status.BEV (bit 22) is hardwired to 1
  assign status_rd = {9'd0, 1'b1, 6'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
  assign cause_rd  = {cause_bd_q, cause_ti_q, 14'd0, cause_ip, 1'b0, cause_exc_q, 2'd0};

  always_comb begin
    cp0_rdata = '0;
    case (ws_cp0_addr)
      AddrBadVAddr: cp0_rdata = badvaddr_q;
      AddrCount:    cp0_rdata = count_q;
      AddrCompare:  cp0_rdata = compare_q;
      AddrStatus:   cp0_rdata = status_rd;
      AddrCause:    cp0_rdata = cause_rd;
      AddrEpc:      cp0_rdata = epc_q;
      default:      cp0_rdata = '0;
    endcase
  end

  // Retire / redirect outputs
  always_comb begin
    rf_wdata = ws_res_from_cp0 ? cp0_rdata : ws_result;
    flush    = 1'b0;
    flush_pc = '0;
    rf_we    = ws_gr_we & {4{ws_valid_q}};
    if (take_exc) begin
      flush    = 1'b1;
      flush_pc = EXC_ENTRY;
      rf_we    = '0;
    end else if (eret_go) begin
      flush    = 1'b1;
      flush_pc = epc_q;
      rf_we    = '0;
    end
  end

  assign pipe.ws_allowin        = ws_allowin;
  assign pipe.ws_to_rf_bus      = {rf_we, ws_dest, rf_wdata};
  assign pipe.stall_ws_bus      = {ws_valid_q & (|ws_gr_we), ws_gr_we & {4{ws_valid_q}}, ws_dest};
  assign pipe.forward_ws_bus    = {ws_valid_q, rf_wdata};
  assign pipe.ws_flush          = flush;
  assign pipe.ws_flush_pc       = flush_pc;
  assign pipe.debug_wb_pc       = ws_pc;
  assign pipe.debug_wb_rf_wen   = rf_we;
  assign pipe.debug_wb_rf_wnum  = ws_dest;
  assign pipe.debug_wb_rf_wdata = rf_wdata;

  // Next-state logic
  always_comb begin
    ws_valid_d    = ws_valid_q;
    ws_bus_d      = ws_bus_q;
    status_im_d   = status_im_q;
    status_exl_d  = status_exl_q;
    status_ie_d   = status_ie_q;
    cause_bd_d    = cause_bd_q;
    cause_ti_d    = cause_ti_q;
    cause_ip_sw_d = cause_ip_sw_q;
    cause_exc_d   = cause_exc_q;
    epc_d         = epc_q;
    badvaddr_d    = badvaddr_q;
    count_d       = count_q;
    compare_d     = compare_q;
    div_d         = div_q;
    // Timer interrupt shares IP[7] with the sixth hardware line
    cause_ip_hw_d = {cause_ti_q | hw_ext[5], hw_ext[4:0]};

    if (ws_allowin) begin
      ws_valid_d = pipe.ms_to_ws_valid;
      if (pipe.ms_to_ws_valid) begin
        ws_bus_d = pipe.ms_to_ws_bus;
      end
    end

    // Free-running timer; an mtc0 below may override it
    if (div_q == DivLast) begin
      div_d   = '0;
      count_d = count_q + 32'd1;
      if (count_q + 32'd1 == compare_q) begin
        cause_ti_d = 1'b1;
      end
    end else begin
      div_d = div_q + DivW'(1);
    end

    if (take_exc) begin
      // A nested exception keeps the original return point
      if (!status_exl_q) begin
        epc_d      = ws_is_slot ? ws_pc - 32'd4 : ws_pc;
        cause_bd_d = ws_is_slot;
      end
      status_exl_d = 1'b1;
      cause_exc_d  = exc_code;
      if (exc_code == ExcAdEL || exc_code == ExcAdES) begin
        badvaddr_d = ws_bad_vaddr;
      end
    end

    if (cp0_we) begin
      case (ws_cp0_addr)
        AddrStatus: begin
          status_im_d  = ws_result[15:8];
          status_exl_d = ws_result[1];
          status_ie_d  = ws_result[0];
        end
        AddrCause:   cause_ip_sw_d = ws_result[9:8];
        AddrEpc:     epc_d = ws_result;
        AddrCount: begin
          count_d = ws_result;
          div_d   = '0;
        end
        AddrCompare: begin
          compare_d  = ws_result;
          cause_ti_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (eret_go) begin
      status_exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q    <= 1'b0;
      ws_bus_q      <= '0;
      status_im_q   <= '0;
      status_exl_q  <= 1'b0;
      status_ie_q   <= 1'b0;
      cause_bd_q    <= 1'b0;
      cause_ti_q    <= 1'b0;
      cause_ip_hw_q <= '0;
      cause_ip_sw_q <= '0;
      cause_exc_q   <= '0;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      count_q       <= '0;
      compare_q     <= '0;
      div_q         <= '0;
    end else begin
      ws_valid_q    <= ws_valid_d;
      ws_bus_q      <= ws_bus_d;
      status_im_q   <= status_im_d;
      status_exl_q  <= status_exl_d;
      status_ie_q   <= status_ie_d;
      cause_bd_q    <= cause_bd_d;
      cause_ti_q    <= cause_ti_d;
      cause_ip_hw_q <= cause_ip_hw_d;
      cause_ip_sw_q <= cause_ip_sw_d;
      cause_exc_q   <= cause_exc_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
      count_q       <= count_d;
      compare_q     <= compare_d;
      div_q         <= div_d;
    end
  end

endmodule

// File: tb/tb_wb_exc_stage.sv
module tb_wb_exc_stage;

  localparam int unsigned CountDiv = 2;
  localparam logic [31:0] ExcEntry = 32'hBFC0_0380;
  localparam logic [7:0] AdrBadv = 8'h40;
  localparam logic [7:0] AdrCount = 8'h48;
  localparam logic [7:0] AdrCompare = 8'h58;
  localparam logic [7:0] AdrStatus = 8'h60;
  localparam logic [7:0] AdrCause = 8'h68;
  localparam logic [7:0] AdrEpc = 8'h70;

  typedef struct packed {
    logic [31:0] bad_vaddr;
    logic [4:0]  ex_code;
    logic        has_exc;
    logic        is_slot;
    logic        eret;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } instr_t;

  typedef struct packed {
    logic        take_exc;
    logic [4:0]  code;
    logic        eret_go;
    logic        cp0_go;
    logic        flush;
    logic [31:0] flush_pc;
    logic [3:0]  rf_we;
    logic [31:0] wdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] hw_int;
  int         checks = 0;
  int         errors = 0;

  wb_exc_stage_if pipe ();

  wb_exc_stage #(
    .NUM_HW_INT(6),
    .COUNT_DIV (CountDiv),
    .EXC_ENTRY (ExcEntry)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hw_int(hw_int),
    .pipe  (pipe)
  );

  always #5 clk = ~clk;

  // ---------------- Reference model (architectural view of CP0) ----------------
  logic        m_valid = 1'b0;
  instr_t      m_ins = '0;
  logic [7:0]  m_im = '0;
  logic        m_ie = 1'b0, m_exl = 1'b0, m_bd = 1'b0, m_ti = 1'b0;
  logic [1:0]  m_ip_sw = '0;
  logic [5:0]  m_hw = '0;
  logic [4:0]  m_code = '0;
  logic [31:0] m_epc = '0, m_badv = '0, m_count = '0, m_compare = '0;
  int unsigned m_div = 0;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [31:0] ip;
    ip = 32'(m_hw) * 4 + 32'(m_ip_sw);
    case (a)
      AdrBadv:    return m_badv;
      AdrCount:   return m_count;
      AdrCompare: return m_compare;
      AdrStatus:  return 32'h0040_0000 + (32'(m_im) << 8) + (32'(m_exl) << 1) + 32'(m_ie);
      AdrCause:   return (32'(m_bd) << 31) + (32'(m_ti) << 30) + (ip << 8) + (32'(m_code) << 2);
      AdrEpc:     return m_epc;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic exp_t m_eval();
    exp_t e;
    logic ireq;
    ireq       = m_ie && !m_exl && (({m_hw, m_ip_sw} & m_im) != 8'd0);
    e.take_exc = m_valid && (ireq || m_ins.has_exc);
    e.code     = (m_valid && ireq) ? 5'd0 : m_ins.ex_code;
    e.eret_go  = m_valid && m_ins.eret && !e.take_exc;
    e.cp0_go   = m_valid && m_ins.cp0_wen && !e.take_exc;
    e.flush    = e.take_exc || e.eret_go;
    e.flush_pc = e.take_exc ? ExcEntry : (e.eret_go ? m_epc : 32'd0);
    e.rf_we    = (e.flush || !m_valid) ? 4'd0 : m_ins.gr_we;
    e.wdata    = m_ins.res_from_cp0 ? m_read(m_ins.cp0_addr) : m_ins.result;
    return e;
  endfunction

  function automatic void m_step(input logic v, input instr_t ins);
    exp_t        e;
    logic        ti_old;
    logic [31:0] wd;
    logic [31:0] cmp_old;
    if (reset) begin
      m_valid = 0; m_ins = '0; m_im = '0; m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0;
      m_ip_sw = '0; m_hw = '0; m_code = '0; m_epc = '0; m_badv = '0;
      m_count = '0; m_compare = '0; m_div = 0;
      return;
    end
    e = m_eval();
    ti_old = m_ti;
    cmp_old = m_compare;
    wd = m_ins.result;
    if (e.cp0_go && m_ins.cp0_addr == AdrCount) begin
      m_div = 0;
    end else if (m_div == CountDiv - 1) begin
      m_div = 0;
      m_count = m_count + 1;
      if (m_count == cmp_old) m_ti = 1;
    end else begin
      m_div = m_div + 1;
    end
    if (e.take_exc) begin
      if (!m_exl) begin
        m_epc = m_ins.is_slot ? m_ins.pc - 32'd4 : m_ins.pc;
        m_bd  = m_ins.is_slot;
      end
      m_exl = 1;
      m_code = e.code;
      if (e.code == 5'd4 || e.code == 5'd5) m_badv = m_ins.bad_vaddr;
    end
    if (e.cp0_go) begin
      case (m_ins.cp0_addr)
        AdrStatus: begin m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0]; end
        AdrCause:   m_ip_sw = wd[9:8];
        AdrEpc:     m_epc = wd;
        AdrCompare: begin m_compare = wd; m_ti = 0; end
        AdrCount:   m_count = wd;
        default: ;
      endcase
    end
    if (e.eret_go) m_exl = 0;
    m_hw = {ti_old | hw_int[5], hw_int[4:0]};
    m_valid = v;
    if (v) m_ins = ins;
  endfunction

  // ---------------- Instruction builders ----------------
  function automatic instr_t mk_alu(input logic [31:0] pc, input logic [4:0] d,
                                    input logic [31:0] r);
    instr_t i;
    i = '0; i.pc = pc; i.dest = d; i.result = r; i.gr_we = 4'hf;
    return i;
  endfunction

  function automatic instr_t mk_mfc0(input logic [31:0] pc, input logic [4:0] d,
                                     input logic [7:0] a);
    instr_t i;
    i = '0; i.pc = pc; i.dest = d; i.gr_we = 4'hf; i.res_from_cp0 = 1; i.cp0_addr = a;
    return i;
  endfunction

  function automatic instr_t mk_mtc0(input logic [31:0] pc, input logic [7:0] a,
                                     input logic [31:0] val);
    instr_t i;
    i = '0; i.pc = pc; i.cp0_wen = 1; i.cp0_addr = a; i.result = val;
    return i;
  endfunction

  function automatic instr_t mk_exc(input logic [31:0] pc, input logic [4:0] code,
                                    input logic slot, input logic [31:0] badv);
    instr_t i;
    i = '0; i.pc = pc; i.has_exc = 1; i.ex_code = code; i.is_slot = slot;
    i.bad_vaddr = badv; i.gr_we = 4'hf; i.dest = 5'd9; i.result = 32'h1234_5678;
    return i;
  endfunction

  function automatic instr_t mk_eret(input logic [31:0] pc);
    instr_t i;
    i = '0; i.pc = pc; i.eret = 1;
    return i;
  endfunction

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 6))
      0: return AdrBadv;
      1: return AdrCount;
      2: return AdrCompare;
      3: return AdrStatus;
      4: return AdrCause;
      5: return AdrEpc;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic instr_t rand_instr(input logic [31:0] pc);
    instr_t i;
    logic [4:0] codes [6] = '{5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
    i = mk_alu(pc, 5'($urandom), $urandom);
    i.gr_we = 4'($urandom);
    i.is_slot = 1'($urandom);
    i.ex_code = 5'($urandom);
    i.bad_vaddr = $urandom;
    case ($urandom_range(0, 9))
      0, 1: begin i = mk_mtc0(pc, rand_addr(), $urandom); end
      2: begin i = mk_mfc0(pc, 5'($urandom), rand_addr()); end
      3: begin
        i.has_exc = 1;
        i.ex_code = codes[$urandom_range(0, 5)];
      end
      4: begin i = mk_eret(pc); end
      default: ;
    endcase
    return i;
  endfunction

  // Drive one instruction slot and advance DUT and model by one clock
  task automatic tick(input logic v, input instr_t ins);
    pipe.ms_to_ws_valid = v;
    pipe.ms_to_ws_bus   = ins;
    m_step(v, ins);
    @(posedge clk);
    #1;
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    hw_int = '0;
    reset = 1'b1;
    tick(1'b1, mk_alu(32'h100, 5'd1, 32'd7));
    tick(1'b0, '0);
    reset = 1'b0;
    checks++;
    if (pipe.ws_allowin !== 1'b1) begin
      errors++; $display("FAIL reset_allowin got=%0b want=1", pipe.ws_allowin);
    end
    checks++;
    if (pipe.ws_flush !== 1'b0 || pipe.ws_to_rf_bus[40:37] !== 4'd0) begin
      errors++;
      $display("FAIL reset_quiet flush=%0b rf_we=%h want 0/0", pipe.ws_flush,
               pipe.ws_to_rf_bus[40:37]);
    end
    tick(1'b1, mk_mfc0(32'h200, 5'd2, AdrStatus));
    checks++;
    if (pipe.ws_to_rf_bus[31:0] !== 32'h0040_0000) begin
      errors++; $display("FAIL reset_status got=%h want=00400000", pipe.ws_to_rf_bus[31:0]);
    end
    tick(1'b1, mk_mfc0(32'h204, 5'd2, AdrCause));
    checks++;
    if (pipe.ws_to_rf_bus[31:0] !== 32'h0) begin
      errors++; $display("FAIL reset_cause got=%h want=0", pipe.ws_to_rf_bus[31:0]);
    end
  endtask

  task automatic test_basic_random();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      tick($urandom_range(0, 3) != 0, mk_alu(32'h1000 + 4 * i, 5'($urandom), $urandom));
      e = m_eval();
      checks++;
      if (pipe.ws_to_rf_bus !== {e.rf_we, m_ins.dest, e.wdata} ||
          pipe.forward_ws_bus !== {m_valid, e.wdata}) begin
        errors++;
        $display("FAIL basic_rf got=%h/%h want=%h/%h", pipe.ws_to_rf_bus, pipe.forward_ws_bus,
                 {e.rf_we, m_ins.dest, e.wdata}, {m_valid, e.wdata});
      end
      checks++;
      if (pipe.stall_ws_bus !== {m_valid & (|m_ins.gr_we), m_ins.gr_we & {4{m_valid}},
                                 m_ins.dest} || pipe.debug_wb_pc !== m_ins.pc) begin
        errors++;
        $display("FAIL basic_stall got=%h pc=%h want pc=%h", pipe.stall_ws_bus,
                 pipe.debug_wb_pc, m_ins.pc);
      end
    end
  endtask

  task automatic test_interrupt();
    hw_int = 6'b000001;
    tick(1'b1, mk_mtc0(32'hBFC0_000C, AdrStatus, 32'h0000_0401));
    checks++;
    if (pipe.ws_flush !== 1'b0) begin
      errors++; $display("FAIL int_early got=%0b want=0", pipe.ws_flush);
    end
    tick(1'b1, mk_alu(32'hBFC0_0010, 5'd3, 32'd99));
    checks++;
    if (pipe.ws_flush !== 1'b1 || pipe.ws_flush_pc !== ExcEntry ||
        pipe.ws_to_rf_bus[40:37] !== 4'd0) begin
      errors++;
      $display("FAIL int_take flush=%0b pc=%h we=%h want 1/%h/0", pipe.ws_flush,
               pipe.ws_flush_pc, pipe.ws_to_rf_bus[40:37], ExcEntry);
    end
    tick(1'b1, mk_mfc0(32'hBFC0_0380, 5'd4, AdrEpc));
    checks++;
    if (pipe.ws_to_rf_bus[31:0] !== 32'hBFC0_0010) begin
      errors++; $display("FAIL int_epc got=%h want=bfc00010", pipe.ws_to_rf_bus[31:0]);
    end
    tick(1'b1, mk_mfc0(32'hBFC0_0384, 5'd4, AdrCause));
    checks++;
    if (pipe.ws_to_rf_bus[6:2] !== 5'd0 || pipe.ws_to_rf_bus[10] !== 1'b1) begin
      errors++; $display("FAIL int_cause got=%h want code 0 IP2 1", pipe.ws_to_rf_bus[31:0]);
    end
    tick(1'b1, mk_mfc0(32'hBFC0_0388, 5'd4, AdrStatus));
    checks++;
    if (pipe.ws_to_rf_bus[31:0] !== 32'h0040_0403) begin
      errors++; $display("FAIL int_exl got=%h want=00400403", pipe.ws_to_rf_bus[31:0]);
    end
    hw_int = '0;
    tick(1'b1, mk_mtc0(32'hBFC0_038C, AdrStatus, 32'h0));
  endtask

  task automatic test_syscall();
    tick(1'b1, mk_exc(32'hBFC0_0104, 5'd8, 1'b1, 32'h0));
    checks++;
    if (pipe.ws_flush !== 1'b1 || pipe.ws_to_rf_bus[40:37] !== 4'd0) begin
      errors++;
      $display("FAIL sys_flush flush=%0b we=%h want 1/0", pipe.ws_flush,
               pipe.ws_to_rf_bus[40:37]);
    end
    tick(1'b1, mk_mfc0(32'hBFC0_0380, 5'd4, AdrEpc));
    checks++;
    if (pipe.ws_to_rf_bus[31:0] !== 32'hBFC0_0100) begin
      errors++; $display("FAIL sys_epc got=%h want=bfc00100", pipe.ws_to_rf_bus[31:0]);
    end
    tick(1'b1, mk_mfc0(32'hBFC0_0384, 5'd4, AdrCause));
    checks++;
    if (pipe.ws_to_rf_bus[31] !== 1'b1 || pipe.ws_to_rf_bus[6:2] !== 5'd8) begin
      errors++; $display("FAIL sys_cause got=%h want BD 1 code 8", pipe.ws_to_rf_bus[31:0]);
    end
  endtask

  // EXL is still set here, so EPC and BD must not move
  task automatic test_adel();
    tick(1'b1, mk_exc(32'hBFC0_0300, 5'd4, 1'b0, 32'h0000_1003));
    tick(1'b1, mk_mfc0(32'hBFC0_0380, 5'd4, AdrBadv));
    checks++;
    if (pipe.ws_to_rf_bus[31:0] !== 32'h0000_1003) begin
      errors++; $display("FAIL adel_badv got=%h want=00001003", pipe.ws_to_rf_bus[31:0]);
    end
    tick(1'b1, mk_mfc0(32'hBFC0_0384, 5'd4, AdrCause));
    checks++;
    if (pipe.ws_to_rf_bus[6:2] !== 5'd4 || pipe.ws_to_rf_bus[31] !== 1'b1) begin
      errors++; $display("FAIL adel_cause got=%h want code 4 BD 1", pipe.ws_to_rf_bus[31:0]);
    end
    tick(1'b1, mk_mfc0(32'hBFC0_0388, 5'd4, AdrEpc));
    checks++;
    if (pipe.ws_to_rf_bus[31:0] !== 32'hBFC0_0100) begin
      errors++; $display("FAIL adel_epc_held got=%h want=bfc00100", pipe.ws_to_rf_bus[31:0]);
    end
  endtask

  task automatic test_eret();
    tick(1'b1, mk_mtc0(32'hBFC0_0390, AdrEpc, 32'hBFC0_0200));
    tick(1'b1, mk_eret(32'hBFC0_0394));
    checks++;
    if (pipe.ws_flush !== 1'b1 || pipe.ws_flush_pc !== 32'hBFC0_0200 ||
        pipe.ws_to_rf_bus[40:37] !== 4'd0) begin
      errors++;
      $display("FAIL eret_flush flush=%0b pc=%h we=%h want 1/bfc00200/0", pipe.ws_flush,
               pipe.ws_flush_pc, pipe.ws_to_rf_bus[40:37]);
    end
    tick(1'b1, mk_mfc0(32'hBFC0_0200, 5'd4, AdrStatus));
    checks++;
    if (pipe.ws_to_rf_bus[1] !== 1'b0) begin
      errors++; $display("FAIL eret_exl got=%h want EXL 0", pipe.ws_to_rf_bus[31:0]);
    end
  endtask

  task automatic test_timer();
    logic [31:0] want [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    tick(1'b1, mk_mtc0(32'h300, AdrCompare, 32'd5));
    tick(1'b1, mk_mtc0(32'h304, AdrCount, 32'd0));
    for (int j = 0; j < 14; j++) begin
      tick(1'b1, mk_mfc0(32'h308 + 4 * j, 5'd5, AdrCause));
      checks++;
      if (pipe.ws_to_rf_bus[30] !== (j >= 10)) begin
        errors++; $display("FAIL timer_ti j=%0d got=%0b want=%0b", j, pipe.ws_to_rf_bus[30],
                           j >= 10);
      end
    end
    tick(1'b1, mk_mtc0(32'h340, AdrCompare, 32'd100));
    tick(1'b1, mk_mfc0(32'h344, 5'd5, AdrCause));
    checks++;
    if (pipe.ws_to_rf_bus[30] !== 1'b0) begin
      errors++; $display("FAIL timer_clear got=%0b want=0", pipe.ws_to_rf_bus[30]);
    end
    tick(1'b1, mk_mtc0(32'h348, AdrCount, 32'hFFFF_FFFF));
    for (int j = 0; j < 3; j++) begin
      tick(1'b1, mk_mfc0(32'h34C + 4 * j, 5'd5, AdrCount));
      checks++;
      if (pipe.ws_to_rf_bus[31:0] !== want[j]) begin
        errors++; $display("FAIL timer_wrap j=%0d got=%h want=%h", j, pipe.ws_to_rf_bus[31:0],
                           want[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, mk_mfc0(32'h400, 5'd2, AdrCount));
    checks++;
    if (pipe.ws_to_rf_bus !== {4'hf, 5'd2, m_count}) begin
      errors++; $display("FAIL b2b_mfc0 got=%h want=%h", pipe.ws_to_rf_bus, {4'hf, 5'd2, m_count});
    end
    for (int i = 0; i < 20; i++) begin
      logic [31:0] r;
      r = $urandom;
      tick(1'b1, mk_alu(32'h404 + 4 * i, 5'd7, r));
      checks++;
      if (pipe.ws_allowin !== 1'b1 || pipe.debug_wb_pc !== 32'h404 + 4 * i ||
          pipe.ws_to_rf_bus !== {4'hf, 5'd7, r}) begin
        errors++;
        $display("FAIL b2b_retire i=%0d allowin=%0b pc=%h rf=%h want pc=%h rf=%h", i,
                 pipe.ws_allowin, pipe.debug_wb_pc, pipe.ws_to_rf_bus, 32'h404 + 4 * i,
                 {4'hf, 5'd7, r});
      end
    end
  endtask

  task automatic test_random_mix();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
      tick($urandom_range(0, 4) != 0, rand_instr(32'h8000 + 4 * i));
      e = m_eval();
      checks++;
      if ({pipe.ws_flush, pipe.ws_flush_pc} !== {e.flush, e.flush_pc}) begin
        errors++;
        $display("FAIL mix_flush i=%0d got=%0b/%h want=%0b/%h", i, pipe.ws_flush,
                 pipe.ws_flush_pc, e.flush, e.flush_pc);
      end
      checks++;
      if (pipe.ws_to_rf_bus !== {e.rf_we, m_ins.dest, e.wdata} ||
          pipe.debug_wb_rf_wen !== e.rf_we || pipe.debug_wb_rf_wdata !== e.wdata) begin
        errors++;
        $display("FAIL mix_rf i=%0d got=%h want=%h", i, pipe.ws_to_rf_bus,
                 {e.rf_we, m_ins.dest, e.wdata});
      end
    end
    hw_int = '0;
  endtask

  task automatic test_reset_mid();
    tick(1'b1, mk_exc(32'h500, 5'd12, 1'b0, 32'h0));
    checks++;
    if (pipe.ws_flush !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got=%0b want=1", pipe.ws_flush);
    end
    reset = 1'b1;
    tick(1'b0, '0);
    reset = 1'b0;
    checks++;
    if (pipe.ws_flush !== 1'b0 || pipe.ws_to_rf_bus[40:37] !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_drop flush=%0b we=%h want 0/0", pipe.ws_flush,
               pipe.ws_to_rf_bus[40:37]);
    end
    tick(1'b1, mk_mfc0(32'h600, 5'd2, AdrStatus));
    checks++;
    if (pipe.ws_to_rf_bus[31:0] !== 32'h0040_0000) begin
      errors++; $display("FAIL rstmid_status got=%h want=00400000", pipe.ws_to_rf_bus[31:0]);
    end
    tick(1'b1, mk_mfc0(32'h604, 5'd2, AdrEpc));
    checks++;
    if (pipe.ws_to_rf_bus[31:0] !== 32'h0) begin
      errors++; $display("FAIL rstmid_epc got=%h want=0", pipe.ws_to_rf_bus[31:0]);
    end
  endtask

  initial begin
    reset = 1'b1;
    hw_int = '0;
    pipe.ms_to_ws_valid = 1'b0;
    pipe.ms_to_ws_bus = '0;
    test_reset();
    test_basic_random();
    test_interrupt();
    test_syscall();
    test_adel();
    test_eret();
    test_timer();
    test_back_to_back();
    test_random_mix();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_exc_stage.md
WB_EXC_STAGE -- requirements
Module: wb_exc_stage

Interface
REQ-001 SHALL have parameter NUM_HW_INT, default 6 (range 1..6): number of hardware interrupt lines.
REQ-002 SHALL have parameter COUNT_DIV, default 2 (range 1..16): clock cycles per Count increment.
REQ-003 SHALL have parameter EXC_ENTRY, default 32'hBFC0_0380: flush target on exception or interrupt.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ws_allowin  out  1  stage can accept a new instruction.
REQ-007 ms_to_ws_valid  in  1  upstream instruction valid.
REQ-008 ms_to_ws_bus  in  123  MSB->LSB: bad_vaddr[32], ex_code[5], has_exc, is_slot, eret, cp0_wen, res_from_cp0, cp0_addr[8], gr_we[4], dest[5], result[32], pc[32].
REQ-009 hw_int  in  NUM_HW_INT  level-sensitive external interrupts.
REQ-010 ws_to_rf_bus  out  41  {rf_we[4], rf_waddr[5], rf_wdata[32]}.
REQ-011 stall_ws_bus  out  10  {valid&|we, we&{4{valid}}, dest}.
REQ-012 forward_ws_bus  out  33  {ws_valid, rf_wdata}.
REQ-013 ws_flush  out  1  pipeline flush request, this cycle.
REQ-014 ws_flush_pc  out  32  fetch redirect target, valid with ws_flush.
REQ-015 debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata  out  32/4/5/32  trace.

Function
REQ-016 ws_ready_go SHALL be 1; ws_allowin = !ws_valid | ws_ready_go; bus register loads when ms_to_ws_valid & ws_allowin; ws_valid <= ms_to_ws_valid when ws_allowin.
REQ-017 CP0 map (cp0_addr={rd,sel}): BadVAddr 8'h40, Count 8'h48, Compare 8'h58, Status 8'h60, Cause 8'h68, EPC 8'h70; other addresses read 0, writes ignored.
REQ-018 rf_wdata SHALL be CP0 read data when res_from_cp0, else result; rf_waddr = dest.
REQ-019 int_req = Status.IE & !Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]); take_int = ws_valid & int_req.
REQ-020 take_exc = ws_valid & (take_int | has_exc); code = 0 if take_int (interrupt beats instruction exception), else ex_code.
REQ-021 On take_exc: rf_we = 0, CP0 write suppressed, ws_flush = 1, ws_flush_pc = EXC_ENTRY; next edge: EXL<=1, Cause.ExcCode<=code, Cause.BD<=is_slot, EPC<=is_slot ? pc-4 : pc (only if EXL was 0; EPC/BD held if EXL already 1).
REQ-022 On take_exc with code 4 (AdEL) or 5 (AdES): BadVAddr <= bad_vaddr.
REQ-023 On ws_valid & eret & !take_exc: ws_flush = 1, ws_flush_pc = EPC, EXL <= 0; rf_we = 0.
REQ-024 Otherwise rf_we = gr_we & {4{ws_valid}}; ws_flush = 0, ws_flush_pc = 0.
REQ-025 mtc0 (ws_valid & cp0_wen & !take_exc) writable bits: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC, Compare, Count all 32 bits; BadVAddr read-only.
REQ-026 Cause.IP[7:2] SHALL sample {TI, hw_int zero-extended to 5 bits} every cycle: IP[7]=TI | (NUM_HW_INT==6 ? hw_int[5] : 0), IP[6:2]=hw_int[4:0].
REQ-027 Divider counts 0..COUNT_DIV-1; Count += 1 (mod 2^32) at wrap; mtc0 Count wins over increment and clears divider.
REQ-028 TI (Cause[30]) SHALL set on the edge where Count increments to equal Compare; mtc0 Compare clears TI same edge (clear wins over set).
REQ-029 Debug outputs: pc, rf_we, dest, rf_wdata as driven to ws_to_rf_bus.

Reset
REQ-030 On reset: ws_valid=0, Status=32'h0040_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, TI=0, divider=0; hence rf_we=0, ws_flush=0, ws_allowin=1.
REQ-031 Reset mid-operation SHALL discard the held instruction and pending flush on the same edge.

Verification
REQ-032 mtc0 Status=32'h0000_0401, hw_int[0]=1, next valid add to r3 -> ws_flush=1, flush_pc=EXC_ENTRY, rf_we=0, EPC=that pc, ExcCode=0, EXL=1.
REQ-033 Syscall (ex_code 8) at pc 32'hBFC0_0104 with is_slot=1 -> EPC=32'hBFC0_0100, BD=1, no register write.
REQ-034 AdEL at bad_vaddr 32'h0000_1003 -> BadVAddr=32'h0000_1003, ExcCode=4.
REQ-035 eret with EPC=32'hBFC0_0200 -> ws_flush=1, flush_pc=32'hBFC0_0200, EXL=0 next cycle.
REQ-036 COUNT_DIV=2, Compare=5, Count=0 -> TI set after 10 cycles; mtc0 Compare clears TI; Count wraps 32'hFFFF_FFFF->0.
REQ-037 mfc0 r2 from Count followed by back-to-back valid instructions -> rf_wdata=Count, one retire per cycle, ws_allowin stays 1.
